data_mem_responder: RTL

- Data-memory responder serving the multicycle core's dMemRead/dMemWrite strobes; it is the memory-side end of the load/store interface.
- Accepts one request at a time, inserts a configurable number of wait states, and performs byte/half/word access per func3.
- Returns load data with the correct extension, or flags an error.
- Sits between the core datapath and a word-organised synchronous RAM array held inside the block.

---
 rtl/data_mem_responder_pkg.sv | 38 +++
 rtl/data_mem_responder_lane_extend.sv | 43 ++++
 rtl/data_mem_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: func3 access codes,
// FSM state encoding, error-cause codes and a func3 legality helper.
package data_mem_responder_pkg;

  localparam logic [2:0] FUNC3_B  = 3'b000;
  localparam logic [2:0] FUNC3_H  = 3'b001;
  localparam logic [2:0] FUNC3_W  = 3'b010;
  localparam logic [2:0] FUNC3_BU = 3'b100;
  localparam logic [2:0] FUNC3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Why a request is rejected; first matching cause wins.
  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_CONFLICT = 3'd1,
    ERR_FUNC3    = 3'd2,
    ERR_RANGE    = 3'd3,
    ERR_ALIGN    = 3'd4
  } err_cause_e;

  // Unsigned load sizes exist only for loads; stores accept B/H/W.
  function automatic logic func3_valid(input logic [2:0] f3, input logic is_write);
    logic ok;
    case (f3)
      FUNC3_B, FUNC3_H, FUNC3_W: ok = 1'b1;
      FUNC3_BU, FUNC3_HU:        ok = ~is_write;
      default:                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_extend.sv
// Picks the addressed byte/half lane out of a RAM word and sign- or
// zero-extends it according to func3. Word accesses ignore the offset,
// half accesses look only at offset bit 1.
module data_mem_responder_lane_extend
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data_o = 32'h0000_0000;
    case (off_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      2'd3:    byte_s = word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (off_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
    case (func3_i)
      FUNC3_B:  data_o = {{24{byte_s[7]}}, byte_s};
      FUNC3_H:  data_o = {{16{half_s[15]}}, half_s};
      FUNC3_W:  data_o = word_i;
      FUNC3_BU: data_o = {24'h00_0000, byte_s};
      FUNC3_HU: data_o = {16'h0000, half_s};
      default:  data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits
// WAIT_CYCLES, then answers with a one-cycle ready or error pulse.
// Build option: define DMEM_ALIGN_CHECK_EN to turn misaligned half/word
// accesses into errors; otherwise misaligned low address bits are ignored.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dMemRead,
  input  logic              dMemWrite,
  input  logic [ADDR_W-1:0] dMemAddr,
  input  logic [31:0]       dMemWdata,
  input  logic [2:0]        func3,
  output logic [31:0]       dMemRdata,
  output logic              dMemReady,
  output logic              dMemErr,
  output logic              dMemBusy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int AW1   = ADDR_W + 1;
  localparam logic [ADDR_W:0] ADDR_LIMIT = AW1'(DEPTH) << 2;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         func3_q, func3_d;
  logic               wr_q, wr_d;
  logic               conflict_q, conflict_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  logic [31:0]        mem_q [0:DEPTH-1];
  logic [31:0]        rd_word_q;
  logic [IDX_W-1:0]   idx_s, rd_idx_s;
  logic [1:0]         off_s;
  logic [3:0]         be_s;
  logic [31:0]        wr_word_s;
  logic [31:0]        load_s;
  logic               range_err_s;
  logic               misalign_s;
  logic               mem_we_s;
  err_cause_e         err_cause_s;

  assign idx_s       = addr_q[IDX_W+1:2];
  assign off_s       = addr_q[1:0];
  assign range_err_s = ({1'b0, addr_q} >= ADDR_LIMIT);
  // While idle the RAM is read at the incoming address so the word is
  // ready even with zero wait states; afterwards it follows the latched one.
  assign rd_idx_s    = (state_q == ST_IDLE) ? dMemAddr[IDX_W+1:2] : idx_s;
  assign mem_we_s    = (state_q == ST_RESP) && wr_q && (err_cause_s == ERR_NONE);

`ifdef DMEM_ALIGN_CHECK_EN
  // Flag half accesses on odd addresses and word accesses off a word boundary.
  always_comb begin
    case (func3_q)
      FUNC3_H, FUNC3_HU: misalign_s = addr_q[0];
      FUNC3_W:           misalign_s = |addr_q[1:0];
      default:           misalign_s = 1'b0;
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  // Classify the latched request; the first failing rule is reported.
  always_comb begin
    err_cause_s = ERR_NONE;
    if (conflict_q) begin
      err_cause_s = ERR_CONFLICT;
    end else if (!func3_valid(func3_q, wr_q)) begin
      err_cause_s = ERR_FUNC3;
    end else if (range_err_s) begin
      err_cause_s = ERR_RANGE;
    end else if (misalign_s) begin
      err_cause_s = ERR_ALIGN;
    end else begin
      err_cause_s = ERR_NONE;
    end
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be_s      = 4'b0000;
    wr_word_s = wdata_q;
    case (func3_q)
      FUNC3_B: begin
        be_s      = 4'b0001 << off_s;
        wr_word_s = {4{wdata_q[7:0]}};
      end
      FUNC3_H: begin
        be_s      = off_s[1] ? 4'b1100 : 4'b0011;
        wr_word_s = {2{wdata_q[15:0]}};
      end
      FUNC3_W: begin
        be_s      = 4'b1111;
        wr_word_s = wdata_q;
      end
      default: begin
        be_s      = 4'b0000;
        wr_word_s = wdata_q;
      end
    endcase
  end

  data_mem_responder_lane_extend u_lane_extend (
    .word_i  (rd_word_q),
    .off_i   (off_s),
    .func3_i (func3_q),
    .data_o  (load_s)
  );

  // RAM array: byte-lane writes and registered read; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[idx_s][8*i +: 8] <= wr_word_s[8*i +: 8];
        end
      end
    end
    rd_word_q <= mem_q[rd_idx_s];
  end

  // Next-state and output decode for the request FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    func3_d    = func3_q;
    wr_d       = wr_q;
    conflict_d = conflict_q;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dMemRead || dMemWrite) begin
          addr_d     = dMemAddr;
          wdata_d    = dMemWdata;
          func3_d    = func3;
          wr_d       = dMemWrite;
          conflict_d = dMemRead & dMemWrite;
          busy_d     = 1'b1;
          cnt_d      = 4'd0;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        if (err_cause_s != ERR_NONE) begin
          err_d   = 1'b1;
          rdata_d = 32'h0000_0000;
        end else if (!wr_q) begin
          ready_d = 1'b1;
          rdata_d = load_s;
        end else begin
          ready_d = 1'b1;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!dMemRead && !dMemWrite) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
      func3_q    <= 3'b000;
      wr_q       <= 1'b0;
      conflict_q <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      func3_q    <= func3_d;
      wr_q       <= wr_d;
      conflict_q <= conflict_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign dMemRdata = rdata_q;
  assign dMemReady = ready_q;
  assign dMemErr   = err_q;
  assign dMemBusy  = busy_q;

endmodule
